// File: rtl/vector_control_sequencer_pkg.sv
// Purpose: shared types for the vector control sequencer slice.
//   instr_type_e - major instruction class carried in instruction_type
//   ctrl_t       - datapath control bundle produced by decode and held by the issue register
//   CTRL_NOP     - all-zero bundle, used for illegal encodings and the idle stage
//   state_e      - sequencer FSM states
// Ports: none (package).
package vector_control_sequencer_pkg;

  typedef enum logic [1:0] {
    TYPE_CONTROL  = 2'b00,
    TYPE_MEMORY   = 2'b01,
    TYPE_DATA     = 2'b10,
    TYPE_RESERVED = 2'b11
  } instr_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src3;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/vector_control_sequencer_if.sv
// Purpose: handshake and control-bundle bus between fetch, the sequencer and the
//   register-read/ALU stage.
// Ports (signals):
//   in_valid/in_ready, instruction_type, func, imm, vector, flush  - fetch side
//   out_valid/out_ready, datapath controls, beat_idx, last_beat, illegal - issue side
// Modports: slave = the sequencer, master = whoever drives fetch and consumes the bundle.
interface vector_control_sequencer_if #(
  parameter int BIDX_W = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        instruction_type;
  logic [1:0]        func;
  logic              imm;
  logic              vector;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              jump_i;
  logic              jump_ci;
  logic              jump_cd;
  logic              mem_to_reg;
  logic              mem_write;
  logic              imm_src;
  logic              vector_op;
  logic              alu_src1;
  logic              alu_src2;
  logic              reg_v_write;
  logic              reg_s_write;
  logic [1:0]        alu_op;
  logic [1:0]        alu_src3;
  logic [BIDX_W-1:0] beat_idx;
  logic              last_beat;
  logic              illegal;

  modport slave (
    input  in_valid, instruction_type, func, imm, vector, flush, out_ready,
    output in_ready, out_valid,
    output jump_i, jump_ci, jump_cd, mem_to_reg, mem_write, imm_src, vector_op,
    output alu_src1, alu_src2, reg_v_write, reg_s_write, alu_op, alu_src3,
    output beat_idx, last_beat, illegal
  );

  modport master (
    output in_valid, instruction_type, func, imm, vector, flush, out_ready,
    input  in_ready, out_valid,
    input  jump_i, jump_ci, jump_cd, mem_to_reg, mem_write, imm_src, vector_op,
    input  alu_src1, alu_src2, reg_v_write, reg_s_write, alu_op, alu_src3,
    input  beat_idx, last_beat, illegal
  );
endinterface

// File: rtl/vector_control_sequencer_decode.sv
// Purpose: purely combinational instruction decode, fields -> {ctrl_t, illegal}.
// Ports:
//   instruction_type in 2  major class (00 control, 01 memory, 10 data, 11 reserved)
//   func             in 2  sub-function
//   imm              in 1  immediate form
//   vector           in 1  vector form
//   ctrl             out   decoded control bundle (CTRL_NOP when illegal)
//   illegal          out 1 encoding is undefined
module vector_ctrl_decode
  import vector_control_sequencer_pkg::*;
(
  input  logic [1:0] instruction_type,
  input  logic [1:0] func,
  input  logic       imm,
  input  logic       vector,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (instr_type_e'(instruction_type))
      TYPE_CONTROL: begin
        if (!imm && func == 2'b00) begin
          ctrl.jump_ci  = 1'b1;
          ctrl.imm_src  = 1'b1;
          ctrl.alu_src3 = 2'b11;
          ctrl.alu_op   = 2'b01;
        end else if (!imm && func == 2'b01) begin
          ctrl.jump_cd  = 1'b1;
          ctrl.imm_src  = 1'b1;
          ctrl.alu_src3 = 2'b11;
          ctrl.alu_op   = 2'b01;
        end else if (imm && func == 2'b00) begin
          ctrl.jump_i   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      TYPE_MEMORY: begin
        ctrl.imm_src  = 1'b1;
        ctrl.alu_src3 = 2'b10;
        if (vector) begin
          ctrl.vector_op = 1'b1;
          ctrl.alu_op    = 2'b10;
        end
        case (func)
          2'b00: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src1  = vector;
          end
          2'b01: begin
            ctrl.mem_to_reg  = 1'b1;
            ctrl.reg_v_write = vector;
            ctrl.reg_s_write = !vector;
          end
          default: illegal = 1'b1;
        endcase
      end
      TYPE_DATA: begin
        ctrl.alu_op = func;
        if (imm) begin
          // Immediate data ops are always scalar; the vector bit is ignored.
          ctrl.alu_src3    = 2'b10;
          ctrl.imm_src     = 1'b1;
          ctrl.reg_s_write = 1'b1;
        end else begin
          ctrl.alu_src3 = 2'b01;
          if (vector && func != 2'b11) begin
            ctrl.alu_src2    = 1'b1;
            ctrl.reg_v_write = 1'b1;
            ctrl.vector_op   = 1'b1;
          end else if (!vector && func[1] == 1'b0) begin
            ctrl.reg_s_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings travel down the pipe as a pure NOP.
    if (illegal) begin
      ctrl = CTRL_NOP;
    end
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Purpose: registered decode stage with valid/ready handshake on both sides.
//   Vector ops are issued as VLEN/LANES back-to-back beats tagged with beat_idx.
// Ports:
//   clk  in 1  clock, rising edge
//   rst  in 1  synchronous active-high reset
//   bus  slave modport of vector_control_sequencer_if (fetch handshake, flush,
//        issue handshake, control bundle, beat_idx, last_beat, illegal)
// Parameters:
//   VLEN  elements per vector register
//   LANES ALU lanes; VLEN must be a multiple of LANES
module vector_control_sequencer
  import vector_control_sequencer_pkg::*;
#(
  parameter int VLEN  = 8,
  parameter int LANES = 4
) (
  input logic                          clk,
  input logic                          rst,
  vector_control_sequencer_if.slave    bus
);

  localparam int BEATS  = VLEN / LANES;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BEATS - 1);

  if (VLEN % LANES != 0) begin : g_bad_cfg
    $error("vector_control_sequencer: VLEN must be a multiple of LANES");
  end

  state_e            state_q, state_n;
  ctrl_t             ctrl_q, ctrl_n;
  logic              illegal_q, illegal_n;
  logic [BIDX_W-1:0] beat_q, beat_n;

  ctrl_t             dec_ctrl;
  logic              dec_illegal;
  logic              out_valid;
  logic              last_beat;
  logic              in_ready;
  logic              accept;

  vector_ctrl_decode u_decode (
    .instruction_type (bus.instruction_type),
    .func             (bus.func),
    .imm              (bus.imm),
    .vector           (bus.vector),
    .ctrl             (dec_ctrl),
    .illegal          (dec_illegal)
  );

  assign out_valid = (state_q == ISSUE);
  // Scalar ops are single-beat; last_beat is gated so the idle stage shows all zeros.
  assign last_beat = out_valid && (beat_q == LAST_IDX || !ctrl_q.vector_op);
  // Flush overrides everything, so nothing can be accepted in a flush cycle.
  assign in_ready  = (!out_valid || (bus.out_ready && last_beat)) && !bus.flush;
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= CTRL_NOP;
      illegal_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_n;
      ctrl_q    <= ctrl_n;
      illegal_q <= illegal_n;
      beat_q    <= beat_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    ctrl_n    = ctrl_q;
    illegal_n = illegal_q;
    beat_n    = beat_q;
    if (bus.flush) begin
      state_n   = IDLE;
      ctrl_n    = CTRL_NOP;
      illegal_n = 1'b0;
      beat_n    = '0;
    end else if (accept) begin
      // Covers both the idle accept and the no-bubble accept on a final beat.
      state_n   = ISSUE;
      ctrl_n    = dec_ctrl;
      illegal_n = dec_illegal;
      beat_n    = '0;
    end else if (out_valid && bus.out_ready) begin
      if (last_beat) begin
        state_n   = IDLE;
        ctrl_n    = CTRL_NOP;
        illegal_n = 1'b0;
        beat_n    = '0;
      end else begin
        beat_n = beat_q + BIDX_W'(1);
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.jump_i      = ctrl_q.jump_i;
  assign bus.jump_ci     = ctrl_q.jump_ci;
  assign bus.jump_cd     = ctrl_q.jump_cd;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.imm_src     = ctrl_q.imm_src;
  assign bus.vector_op   = ctrl_q.vector_op;
  assign bus.alu_src1    = ctrl_q.alu_src1;
  assign bus.alu_src2    = ctrl_q.alu_src2;
  assign bus.reg_v_write = ctrl_q.reg_v_write;
  assign bus.reg_s_write = ctrl_q.reg_s_write;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.alu_src3    = ctrl_q.alu_src3;
  assign bus.beat_idx    = beat_q;
  assign bus.last_beat   = last_beat;
  assign bus.illegal     = illegal_q;

endmodule
